// File: rtl/seg_digit_scanner.sv
// seg_digit_scanner: 4-digit seven-segment scan driver with frame-synchronous value update (optional LEADING_ZERO_BLANK_EN)
module seg_digit_scanner #(
    parameter int CLK_DIV      = 50000,
    parameter int GUARD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        blank_all,
    output logic [1:0]  dig_sel,
    output logic [3:0]  nibble,
    output logic [3:0]  anodes,
    output logic        frame_start,
    output logic        pending
);
    localparam int PW = $clog2(CLK_DIV);

    logic [PW-1:0] presc;
    logic [PW-1:0] presc_nx;
    logic [15:0]   display_reg;
    logic [15:0]   pend_reg;
    logic [15:0]   display_nx;
    logic [1:0]    dig_nx;
    logic [3:0]    lit_nx;
    logic [3:0]    an_nx;
    logic          tick;
    logic          boundary;

    // Next-state values; outputs are registered from these so dig_sel, nibble and anodes move together
    always_comb begin
        tick       = presc == PW'(CLK_DIV - 1);
        boundary   = tick && dig_sel == 2'd3;
        presc_nx   = tick ? '0 : presc + 1'b1;
        dig_nx     = tick ? dig_sel + 2'd1 : dig_sel;
        display_nx = !boundary ? display_reg : load ? value : pending ? pend_reg : display_reg;
`ifdef LEADING_ZERO_BLANK_EN
        lit_nx     = (4'b0001 << dig_nx) & {|display_nx[15:12], |display_nx[15:8], |display_nx[15:4], 1'b1};
`else
        lit_nx     = 4'b0001 << dig_nx;
`endif
        an_nx      = (blank_all || presc_nx < PW'(GUARD_CYCLES)) ? 4'hF : ~lit_nx;
    end

    // Scan counters, display/pending buffers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            presc       <= '0;
            dig_sel     <= 2'd0;
            nibble      <= 4'd0;
            anodes      <= 4'hF;
            frame_start <= 1'b0;
            pending     <= 1'b0;
            display_reg <= 16'd0;
            pend_reg    <= 16'd0;
        end else begin
            presc       <= presc_nx;
            dig_sel     <= dig_nx;
            nibble      <= display_nx[{dig_nx, 2'b00} +: 4];
            anodes      <= an_nx;
            frame_start <= boundary;
            display_reg <= display_nx;
            pending     <= boundary ? 1'b0 : load ? 1'b1 : pending;
            pend_reg    <= load ? value : pend_reg;
        end
    end
endmodule

// File: tb/tb_seg_digit_scanner.sv
// tb_seg_digit_scanner: randomized self-checking bench against a cycle-count reference model
module tb_seg_digit_scanner;
    localparam int DIV   = 8;
    localparam int GUARD = 2;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic        blank_all;
    logic [1:0]  dig_sel;
    logic [3:0]  nibble;
    logic [3:0]  anodes;
    logic        frame_start;
    logic        pending;

    int checks = 0;
    int errors = 0;

    int          k;
    logic [15:0] m_disp;
    logic [15:0] m_pv;
    logic        m_pf;
    logic        m_fs;

    seg_digit_scanner #(.CLK_DIV(DIV), .GUARD_CYCLES(GUARD)) dut (
        .clk(clk), .rst(rst), .value(value), .load(load), .blank_all(blank_all),
        .dig_sel(dig_sel), .nibble(nibble), .anodes(anodes),
        .frame_start(frame_start), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at k=%0d got %h exp %h", tag, k, got, exp);
        end
    endtask

    // One clock: advance the model from the inputs seen at the edge, then compare every output
    task automatic step();
        logic       b;
        int         d;
        int         n;
        logic [3:0] ea;
        @(posedge clk);
        #1;
        if (rst) begin
            k = 0; m_disp = 0; m_pv = 0; m_pf = 0; m_fs = 0;
        end else begin
            b = (k % FRAME) == FRAME - 1;
            k++;
            m_fs = b;
            if (b) begin
                m_disp = load ? value : (m_pf ? m_pv : m_disp);
                m_pf = 0;
            end else if (load) begin
                m_pv = value;
                m_pf = 1;
            end
        end
        d = (k / DIV) % 4;
        n = k % DIV;
        ea = 4'hF;
        if (!rst && !blank_all && n >= GUARD) ea = ~(4'b0001 << d);
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && (m_disp >> (4 * d)) == 16'd0) ea = 4'hF;
`endif
        check("dig_sel", 16'(dig_sel), 16'(d));
        check("nibble", 16'(nibble), 16'((m_disp >> (4 * d)) & 16'hF));
        check("anodes", 16'(anodes), 16'(ea));
        check("frame_start", 16'(frame_start), 16'(m_fs));
        check("pending", 16'(pending), 16'(m_pf));
    endtask

    initial begin
        rst = 1; load = 0; value = 0; blank_all = 0;
        k = 0; m_disp = 0; m_pv = 0; m_pf = 0; m_fs = 0;
        repeat (3) step();
        rst = 0;
        repeat (40) step();
        value = 16'h1A2B; load = 1; step(); load = 0;
        repeat (60) step();
        value = 16'h1111; load = 1; step(); load = 0;
        repeat (3) step();
        value = 16'h2222; load = 1; step(); load = 0;
        repeat (40) step();
        while (k % FRAME != FRAME - 1) step();
        value = 16'h00A5; load = 1; step(); load = 0;
        repeat (40) step();
        blank_all = 1; repeat (5) step(); blank_all = 0;
        repeat (20) step();
        value = 16'h0000; load = 1; step(); load = 0;
        repeat (40) step();
        value = 16'hBEEF; load = 1; step(); load = 0;
        repeat (3) step();
        rst = 1; step(); rst = 0;
        repeat (40) step();
        repeat (4000) begin
            rst = $urandom_range(0, 299) == 0;
            load = $urandom_range(0, 15) == 0;
            blank_all = $urandom_range(0, 9) == 0;
            value = 16'($urandom) >> (4 * $urandom_range(0, 4));
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
